frame_fetch: RTL and testbench

//  Pixel prefetch stage between the RP2040 frame-buffer pins and the VGA pixel output.
//  It drives the frame_reset / frame_next_pixel strobes towards the RP2040 and samples the 4-bit gray nibble the RP2040 returns.

---
 rtl/frame_fetch_if.sv | 34 +++
 rtl/frame_fetch.sv | 148 ++++++++++++++
 tb/tb_frame_fetch.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/frame_fetch_if.sv
// rtl/frame_fetch_if.sv - pixel read and RP2040 strobe signals of the frame fetch stage
//
// Purpose: bundles the VGA-side pop interface and the RP2040 frame-buffer pins.
// Signals:
//   frame_start           VGA timing -> fetch: 1-cycle restart pulse
//   pix_rd                VGA -> fetch: pop head pixel this cycle
//   pix_data[3:0]         fetch -> VGA: head gray value (0 when empty)
//   pix_valid             fetch -> VGA: FIFO not empty
//   underflow             fetch -> VGA: sticky pop-while-empty flag
//   frame_reset_out       fetch -> RP2040: rewind frame pointer
//   frame_next_pixel_out  fetch -> RP2040: advance and present next pixel
//   frame_pixel_in[3:0]   RP2040 -> fetch: pixel nibble
// Modports: slave = the fetch block, master = its environment.

interface frame_fetch_if;
  logic       frame_start;
  logic       pix_rd;
  logic [3:0] pix_data;
  logic       pix_valid;
  logic       underflow;
  logic       frame_reset_out;
  logic       frame_next_pixel_out;
  logic [3:0] frame_pixel_in;

  modport slave (
    input  frame_start, pix_rd, frame_pixel_in,
    output pix_data, pix_valid, underflow, frame_reset_out, frame_next_pixel_out
  );

  modport master (
    output frame_start, pix_rd, frame_pixel_in,
    input  pix_data, pix_valid, underflow, frame_reset_out, frame_next_pixel_out
  );
endinterface

// File: rtl/frame_fetch.sv
// rtl/frame_fetch.sv - RP2040 pixel prefetch FIFO feeding the VGA pixel output
//
// Purpose: strobes the RP2040 frame buffer (reset / next pixel), samples the
// returned gray nibble after a settle delay and queues it in a small show-ahead
// FIFO so the VGA stage can pop one pixel per slot with zero latency.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    frame_fetch_if.slave (frame_start, pix_rd, pix_data, pix_valid,
//          underflow, frame_reset_out, frame_next_pixel_out, frame_pixel_in)
// Parameters: DEPTH (FIFO entries, power of 2), SETTLE (cycles from strobe to
// sample), RST_CYCLES (frame_reset_out high time).

module frame_fetch #(
  parameter int DEPTH      = 4,
  parameter int SETTLE     = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  frame_fetch_if.slave bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [AW:0]   FULL_CNT    = DEPTH[AW:0];
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_REQ,
    S_WAIT,
    S_CAP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          reset_q, next_q;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          underflow_q;
  logic          empty, room, wr_en, rd_en;

  assign empty = (count == '0);
  // Nothing is in flight while in REQ, so the reservation check reduces to
  // count < DEPTH; the slot then stays reserved through WAIT/CAP because only
  // pops can change count meanwhile.
  assign room  = (count < FULL_CNT);
  assign rd_en = bus.pix_rd && !empty && !bus.frame_start;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    wr_en   = 1'b0;
    case (state)
      S_IDLE: cnt_n = '0;
      S_RST: begin
        if (cnt == RST_LAST) begin
          state_n = S_REQ;
          cnt_n   = '0;
        end
      end
      S_REQ: begin
        cnt_n = '0;
        if (room) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == SETTLE_LAST) begin
          state_n = S_CAP;
          cnt_n   = '0;
        end
      end
      S_CAP: begin
        cnt_n   = '0;
        wr_en   = 1'b1;
        state_n = S_REQ;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    // A restart overrides everything, including a capture due this cycle.
    if (bus.frame_start) begin
      state_n = S_RST;
      cnt_n   = '0;
      wr_en   = 1'b0;
    end
  end

  // Strobes are decoded from the next state so they are plain flops: reset is
  // high for exactly the RST cycles, next_pixel for the first WAIT cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      reset_q <= 1'b0;
      next_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      reset_q <= (state_n == S_RST);
      next_q  <= (state == S_REQ) && (state_n == S_WAIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      underflow_q <= 1'b0;
    end else if (bus.frame_start) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      // A pop on an empty FIFO never counts, so a same-cycle capture still
      // lands and leaves one entry.
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.pix_rd && empty) underflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.frame_pixel_in;
  end

  assign bus.pix_data             = empty ? 4'h0 : mem[rd_ptr];
  assign bus.pix_valid            = !empty;
  assign bus.underflow            = underflow_q;
  assign bus.frame_reset_out      = reset_q;
  assign bus.frame_next_pixel_out = next_q;

endmodule

// File: tb/tb_frame_fetch.sv
// tb/tb_frame_fetch.sv - directed self-checking bench for frame_fetch

module tb_frame_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_fetch_if bus();

  frame_fetch #(.DEPTH(4), .SETTLE(2), .RST_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model_pix(input int k);
    case (k)
      0:       return 4'h3;
      1:       return 4'h7;
      2:       return 4'hA;
      3:       return 4'hF;
      default: return 4'((k * 3 + 1) % 16);
    endcase
  endfunction

  // RP2040 frame buffer: rewinds on reset, presents the next pixel on each pulse.
  int px_idx = -1;
  always @(negedge clk) begin
    if (bus.frame_reset_out) px_idx = -1;
    else if (bus.frame_next_pixel_out) px_idx = px_idx + 1;
    bus.frame_pixel_in = (px_idx < 0) ? 4'h0 : model_pix(px_idx);
  end

  typedef struct {
    logic       rd;
    logic       valid;
    logic [3:0] data;
    logic       uf;
  } vec_t;

  vec_t vt [7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, rst_hi, np_n, cyc, n, to;
    int pcyc [8];

    // Pop every cycle from a full FIFO holding pixels 0..3, then idle.
    vt[0] = '{rd: 1'b1, valid: 1'b1, data: 4'h3, uf: 1'b0};
    vt[1] = '{rd: 1'b1, valid: 1'b1, data: 4'h7, uf: 1'b0};
    vt[2] = '{rd: 1'b1, valid: 1'b1, data: 4'hA, uf: 1'b0};
    vt[3] = '{rd: 1'b1, valid: 1'b1, data: 4'hF, uf: 1'b0};
    vt[4] = '{rd: 1'b1, valid: 1'b0, data: 4'h0, uf: 1'b0};
    vt[5] = '{rd: 1'b0, valid: 1'b1, data: 4'hD, uf: 1'b1};
    vt[6] = '{rd: 1'b0, valid: 1'b1, data: 4'hD, uf: 1'b1};

    bus.frame_start = 1'b0;
    bus.pix_rd      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_reset_out", bus.frame_reset_out, 0);
    check("rst_next_pixel", bus.frame_next_pixel_out, 0);
    check("rst_pix_valid", bus.pix_valid, 0);
    check("rst_pix_data", bus.pix_data, 0);
    check("rst_underflow", bus.underflow, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.frame_reset_out || bus.frame_next_pixel_out) bad++;
    end
    check("idle_strobes", bad, 0);

    // Frame start and fill
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    rst_hi = 0; np_n = 0; bad = 0;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (bus.frame_reset_out) rst_hi++;
      if (bus.frame_reset_out && bus.frame_next_pixel_out) bad++;
      if (bus.frame_next_pixel_out) begin
        if (np_n < 8) pcyc[np_n] = cyc;
        np_n++;
      end
    end
    check("fill_reset_cycles", rst_hi, 4);
    check("fill_strobe_overlap", bad, 0);
    check("fill_pulse_count", np_n, 4);
    check("fill_first_pulse", pcyc[0], 5);
    for (int i = 1; i < 4; i++) check("fill_pulse_spacing", pcyc[i] - pcyc[i-1], 4);
    check("fill_valid", bus.pix_valid, 1);
    check("fill_head", bus.pix_data, 4'h3);

    // Underflow from full (table)
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 bus.pix_rd = vt[i].rd;
      @(negedge clk);
      check($sformatf("uf_row%0d_valid", i), bus.pix_valid, vt[i].valid);
      check($sformatf("uf_row%0d_data", i), bus.pix_data, vt[i].data);
      check($sformatf("uf_row%0d_flag", i), bus.underflow, vt[i].uf);
    end
    @(posedge clk); #1 bus.pix_rd = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("uf_sticky", bus.underflow, 1);
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    @(negedge clk);
    check("uf_cleared", bus.underflow, 0);
    check("uf_flushed", bus.pix_valid, 0);

    // Drain/refill: one pop per 8 cycles
    repeat (40) @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1 bus.pix_rd = 1'b1;
      @(negedge clk);
      check($sformatf("drain_valid%0d", k), bus.pix_valid, 1);
      check($sformatf("drain_data%0d", k), bus.pix_data, model_pix(k));
      @(posedge clk); #1 bus.pix_rd = 1'b0;
      repeat (6) @(posedge clk);
    end
    @(negedge clk);
    check("drain_no_underflow", bus.underflow, 0);

    // Mid-frame restart during WAIT with two entries stored
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    n = 0; to = 0;
    while (n < 3 && to < 100) begin
      @(negedge clk);
      to++;
      if (bus.frame_next_pixel_out) n++;
    end
    check("restart_pulses", n, 3);
    check("restart_head_before", bus.pix_data, 4'h3);
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    @(negedge clk);
    check("restart_flushed", bus.pix_valid, 0);
    check("restart_reset_out", bus.frame_reset_out, 1);
    to = 0;
    while (!bus.pix_valid && to < 100) begin
      @(negedge clk);
      to++;
    end
    check("restart_valid", bus.pix_valid, 1);
    check("restart_first_pixel", bus.pix_data, model_pix(0));

    // Async reset while next_pixel is high
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (!bus.frame_next_pixel_out && to < 100);
    check("areset_pulse_seen", bus.frame_next_pixel_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_next_pixel", bus.frame_next_pixel_out, 0);
    check("areset_reset_out", bus.frame_reset_out, 0);
    check("areset_pix_valid", bus.pix_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.frame_reset_out || bus.frame_next_pixel_out || bus.pix_valid) bad++;
    end
    check("areset_idle", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
